// File: rtl/div_unit.sv
// div_unit: multi-cycle radix-2 restoring integer divider for the execute stage.
// Produces {HI, LO} = {remainder, quotient} for DIV (signed) and DIVU (unsigned).
// One quotient bit per cycle; magnitudes are divided and the signs are
// re-applied when the result register is loaded.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 signed_div,
    input  logic                 annul,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [2*WIDTH-1:0]   result,
    output logic                 ready,
    output logic                 busy
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     dvd_q, dvd_d;      // dividend magnitude, becomes quotient
    logic [WIDTH-1:0]     dvs_q, dvs_d;      // divisor magnitude
    logic [WIDTH-1:0]     rem_q, rem_d;      // partial remainder (always < divisor)
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 qneg_q, qneg_d;
    logic                 rneg_q, rneg_d;
    logic [2*WIDTH-1:0]   result_q, result_d;

    // Signed views of the operands for sign detection.
    logic signed [WIDTH-1:0] a_s;
    logic signed [WIDTH-1:0] b_s;
    logic                    a_neg;
    logic                    b_neg;

    // One restoring step: shifted remainder, trial subtraction, outcome.
    logic [WIDTH:0]          rem_sh;
    logic signed [WIDTH:0]   trial;
    logic                    q_bit;
    logic [WIDTH-1:0]        rem_nxt;
    logic [WIDTH-1:0]        dvd_nxt;

    // Two's-complement negation when neg is set. The most negative value maps
    // onto itself, which is exactly the unsigned magnitude it represents.
    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v,
                                                  input logic             neg);
        logic [WIDTH-1:0] r;
        r = neg ? (~v + WIDTH'(1)) : v;
        return r;
    endfunction

    assign a_s   = a;
    assign b_s   = b;
    assign a_neg = signed_div & (a_s < 0);
    assign b_neg = signed_div & (b_s < 0);

    // Single iteration of the restoring divider. The shifted remainder is
    // below 2*divisor, so the sign of the (WIDTH+1)-bit trial difference is
    // exactly the borrow: no borrow means the divisor fits and the bit is 1.
    always_comb begin
        rem_sh  = {rem_q, dvd_q[WIDTH-1]};
        trial   = $signed(rem_sh - {1'b0, dvs_q});
        q_bit   = ~trial[WIDTH];
        rem_nxt = q_bit ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
        dvd_nxt = {dvd_q[WIDTH-2:0], q_bit};
    end

    // Next-state, datapath updates and the busy/ready handshake.
    always_comb begin
        state_d  = state_q;
        dvd_d    = dvd_q;
        dvs_d    = dvs_q;
        rem_d    = rem_q;
        cnt_d    = cnt_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        result_d = result_q;
        busy     = 1'b0;
        ready    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start && !annul) begin
                    busy   = 1'b1;
                    dvd_d  = cond_neg(a, a_neg);
                    dvs_d  = cond_neg(b, b_neg);
                    rem_d  = '0;
                    cnt_d  = '0;
                    qneg_d = a_neg ^ b_neg;
                    rneg_d = a_neg;
                    if (b == '0) begin
                        // Divide by zero: quotient all-ones, remainder is the raw dividend.
                        state_d  = DONE;
                        result_d = {a, {WIDTH{1'b1}}};
                    end else begin
                        state_d = CALC;
                    end
                end
            end

            CALC: begin
                busy = 1'b1;
                if (annul) begin
                    // Flushed instruction: drop the work, keep the old result.
                    state_d = IDLE;
                end else begin
                    dvd_d = dvd_nxt;
                    rem_d = rem_nxt;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_d  = DONE;
                        result_d = {cond_neg(rem_nxt, rneg_q), cond_neg(dvd_nxt, qneg_q)};
                    end
                end
            end

            DONE: begin
                ready   = ~annul;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // The hazard unit must never see a stall request while in reset.
        if (rst) begin
            busy = 1'b0;
        end
    end

    // Control state and the architecturally visible result register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    // Datapath working registers; their contents only matter inside an operation.
    always_ff @(posedge clk) begin
        dvd_q  <= dvd_d;
        dvs_q  <= dvs_d;
        rem_q  <= rem_d;
        qneg_q <= qneg_d;
        rneg_q <= rneg_d;
    end

    assign result = result_q;

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: scoreboard bench for div_unit (WIDTH = 32).
module tb_div_unit;

    localparam int W = 32;

    logic            clk;
    logic            rst;
    logic            start;
    logic            signed_div;
    logic            annul;
    logic [W-1:0]    a;
    logic [W-1:0]    b;
    logic [2*W-1:0]  result;
    logic            ready;
    logic            busy;

    int              n_checks;
    int              n_errors;
    logic [2*W-1:0]  sb_q[$];
    logic [2*W-1:0]  last_res;

    div_unit #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .signed_div (signed_div),
        .annul      (annul),
        .a          (a),
        .b          (b),
        .result     (result),
        .ready      (ready),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [2*W-1:0] obs, input logic [2*W-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Reference result: behavioural division on wide signed integers.
    function automatic logic [2*W-1:0] model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                             input logic sg);
        longint sa, sb, q, r;
        logic [W-1:0] uq, ur;
        if (bv == 0) return {av, {W{1'b1}}};
        if (sg) begin
            sa = longint'($signed(av));
            sb = longint'($signed(bv));
            q  = sa / sb;
            r  = sa % sb;
            return {r[W-1:0], q[W-1:0]};
        end
        uq = av / bv;
        ur = av % bv;
        return {ur, uq};
    endfunction

    // Compare every completion against the oldest outstanding expectation.
    always @(negedge clk) begin
        if (ready === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("spurious_ready", 1, 0);
            end else begin
                check("result", result, sb_q.pop_front());
            end
        end
    end

    // Issue one divide in the current cycle and wait (bounded) for ready.
    task automatic run_div(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sg,
                           input logic [2*W-1:0] exp, input string tag);
        int lat;
        int rdy_cyc;
        int busy_cnt;
        lat        = (bv == 0) ? 1 : W + 1;
        a          = av;
        b          = bv;
        signed_div = sg;
        start      = 1'b1;
        sb_q.push_back(exp);
        rdy_cyc    = -1;
        busy_cnt   = 0;
        for (int cyc = 0; cyc <= W + 8; cyc++) begin
            @(negedge clk);
            if (busy === 1'b1) busy_cnt++;
            if (ready === 1'b1) rdy_cyc = cyc;
            @(posedge clk);
            #1;
            start = 1'b0;
            if (rdy_cyc >= 0) break;
        end
        check({tag, "_ready_cycle"}, rdy_cyc, lat);
        check({tag, "_busy_cycles"}, busy_cnt, lat);
        last_res = exp;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_cnt;
        logic [W-1:0] ra, rb;
        logic         rs;

        n_checks   = 0;
        n_errors   = 0;
        rst        = 1'b1;
        start      = 1'b0;
        signed_div = 1'b0;
        annul      = 1'b0;
        a          = '0;
        b          = '0;
        last_res   = '0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_ready", ready, 0);
        check("rst_result", result, 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_busy", busy, 0);
        check("idle_ready", ready, 0);
        @(posedge clk);
        #1;

        // Directed cases with hand-derived expectations.
        run_div(32'd100, 32'd7, 1'b0, {32'd2, 32'd14}, "u100_7");
        run_div(32'hFFFF_FFF9, 32'd2, 1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, "s_m7_2");
        run_div(32'hFFFF_FFF9, 32'd2, 1'b0, {32'd1, 32'h7FFF_FFFC}, "u_m7_2");
        run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, {32'd0, 32'h8000_0000}, "s_ovf");
        run_div(32'h8000_0000, 32'd1, 1'b1, {32'd0, 32'h8000_0000}, "s_min_1");
        run_div(32'h0000_1234, 32'd0, 1'b1, {32'h0000_1234, 32'hFFFF_FFFF}, "s_div0");
        run_div(32'hFFFF_FFF0, 32'd0, 1'b1, {32'hFFFF_FFF0, 32'hFFFF_FFFF}, "s_div0_neg");
        run_div(32'h0000_1234, 32'd0, 1'b0, {32'h0000_1234, 32'hFFFF_FFFF}, "u_div0");

        // Annul in CALC cycle 10, then a new divide accepted in cycle 11.
        a = 32'd100; b = 32'd7; signed_div = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        annul = 1'b1;
        @(negedge clk);
        check("annul_c10_busy", busy, 1);
        @(posedge clk);
        #1;
        annul = 1'b0;
        check("annul_c11_busy", busy, 0);
        check("annul_result_kept", result, last_res);
        run_div(32'd9, 32'd3, 1'b0, {32'd0, 32'd3}, "after_annul");

        // Annul while idle suppresses acceptance.
        a = 32'd5; b = 32'd1; signed_div = 1'b0; start = 1'b1; annul = 1'b1;
        @(negedge clk);
        check("annul_idle_busy", busy, 0);
        @(posedge clk);
        #1;
        start = 1'b0; annul = 1'b0;
        @(negedge clk);
        check("annul_idle_next_busy", busy, 0);
        @(posedge clk);
        #1;

        // Annul in DONE gates ready but the result register is already loaded.
        a = 32'h55; b = 32'd0; signed_div = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; annul = 1'b1;
        @(negedge clk);
        check("annul_done_ready", ready, 0);
        check("annul_done_result", result, {32'h55, 32'hFFFF_FFFF});
        @(posedge clk);
        #1;
        annul = 1'b0;
        last_res = {32'h55, 32'hFFFF_FFFF};
        @(negedge clk);
        check("after_done_ready", ready, 0);
        @(posedge clk);
        #1;

        // Random operands against the behavioural model.
        for (int i = 0; i < 16; i++) begin
            ra = $urandom;
            case (i % 4)
                0: rb = $urandom;
                1: rb = $urandom_range(1, 15);
                2: rb = -($urandom_range(1, 9));
                default: rb = $urandom & 32'h0000_FFFF;
            endcase
            rs = 1'($urandom_range(0, 1));
            run_div(ra, rb, rs, model(ra, rb, rs), "rand");
        end

        // Reset in cycle 5 of a divide, with start held high during reset.
        a = 32'd100; b = 32'd7; signed_div = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1; start = 1'b1;
        @(negedge clk);
        check("midrst_c5_busy", busy, 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("midrst_c6_busy", busy, 0);
        check("midrst_c6_ready", ready, 0);
        check("midrst_c6_result", result, 0);
        @(posedge clk);
        #1;
        rst = 1'b0; start = 1'b0;
        busy_cnt = 0;
        for (int c = 0; c < W + 8; c++) begin
            @(negedge clk);
            if (busy === 1'b1) busy_cnt++;
        end
        check("midrst_busy_after", busy_cnt, 0);
        check("midrst_result_after", result, 0);

        check("sb_empty", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
